// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS front-end pipeline registers: control bundle
// layout, NOP encoding and the default reset PC.
package mips_pipe_pkg;

    localparam int unsigned CTRL_W = 8;

    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_ALUCTL_HI = 4;
    localparam int unsigned CTRL_ALUCTL_LO = 2;
    localparam int unsigned CTRL_ALUSRC = 1;
    localparam int unsigned CTRL_REGDST = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/hazard_pipe_regs_pipe_reg.sv
// Generic pipeline register: sync reset beats clear, clear beats enable.
module pipe_reg #(
    parameter int unsigned Width = 32,
    parameter logic [Width-1:0] ResetVal = '0,
    parameter logic [Width-1:0] ClrVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = ClrVal;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= ResetVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX registers driven by the hazard unit's stall/flush
// controls, with per-stage valid bits and saturating stall/flush counters.
module hazard_pipe_regs #(
    parameter logic [31:0] RESET_PC = mips_pipe_pkg::RESET_PC_DEFAULT,
    parameter int unsigned CTRL_W = mips_pipe_pkg::CTRL_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       SignImmD,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [4:0]        RdD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       SignImmE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        RdE,
    output logic              ValidE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    import mips_pipe_pkg::*;

    localparam int unsigned IfIdW = 32 + 32 + 1;
    localparam int unsigned IdExW = CTRL_W + 3 * 32 + 3 * 5 + 1;
    localparam logic [IfIdW-1:0] IfIdClr = {NOP_INSTR, 32'h0, 1'b0};

    // A stalled decode stage must not be flushed: PCSrcD is computed on stale operands.
    logic flush_d_eff;
    assign flush_d_eff = FlushD & ~StallD;

    pipe_reg #(
        .Width    (32),
        .ResetVal (RESET_PC),
        .ClrVal   (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (~StallF),
        .clr_i (1'b0),
        .d_i   (PCNextF),
        .q_o   (PCF)
    );

    pipe_reg #(
        .Width    (IfIdW),
        .ResetVal ('0),
        .ClrVal   (IfIdClr)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (~StallD),
        .clr_i (flush_d_eff),
        .d_i   ({InstrF, PCPlus4F, 1'b1}),
        .q_o   ({InstrD, PCPlus4D, ValidD})
    );

    pipe_reg #(
        .Width    (IdExW),
        .ResetVal ('0),
        .ClrVal   ('0)
    ) u_idex_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .clr_i (FlushE),
        .d_i   ({CtrlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD, ValidD}),
        .q_o   ({CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE})
    );

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((FlushE || flush_d_eff) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Directed plus randomized bench for hazard_pipe_regs against a
// cycle-level behavioural model of the pipeline register rules.
module tb_hazard_pipe_regs;

    localparam int CntMax = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCNextF, InstrF, PCPlus4F;
    logic        StallF, StallD, FlushD, FlushE;
    logic [7:0]  CtrlD;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD, ValidE;
    logic [7:0]  CtrlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RsE, RtE, RdE;
    logic [3:0]  StallCnt, FlushCnt;

    int n_vec = 0;
    int n_bad = 0;

    // Expected architectural state of each stage.
    logic [31:0] m_pcf, m_instrd, m_pcp4d, m_rd1e, m_rd2e, m_imme;
    logic        m_validd, m_valide;
    logic [7:0]  m_ctrle;
    logic [4:0]  m_rse, m_rte, m_rde;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    hazard_pipe_regs #(
        .RESET_PC (32'h0),
        .CTRL_W   (8),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PCNextF  (PCNextF),
        .InstrF   (InstrF),
        .PCPlus4F (PCPlus4F),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .FlushE   (FlushE),
        .CtrlD    (CtrlD),
        .RD1D     (RD1D),
        .RD2D     (RD2D),
        .SignImmD (SignImmD),
        .RsD      (RsD),
        .RtD      (RtD),
        .RdD      (RdD),
        .PCF      (PCF),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
        .CtrlE    (CtrlE),
        .RD1E     (RD1E),
        .RD2E     (RD2E),
        .SignImmE (SignImmE),
        .RsE      (RsE),
        .RtE      (RtE),
        .RdE      (RdE),
        .ValidE   (ValidE),
        .StallCnt (StallCnt),
        .FlushCnt (FlushCnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("PCF", 64'(PCF), 64'(m_pcf));
        check("InstrD", 64'(InstrD), 64'(m_instrd));
        check("PCPlus4D", 64'(PCPlus4D), 64'(m_pcp4d));
        check("ValidD", 64'(ValidD), 64'(m_validd));
        check("CtrlE", 64'(CtrlE), 64'(m_ctrle));
        check("RD1E", 64'(RD1E), 64'(m_rd1e));
        check("RD2E", 64'(RD2E), 64'(m_rd2e));
        check("SignImmE", 64'(SignImmE), 64'(m_imme));
        check("RsE", 64'(RsE), 64'(m_rse));
        check("RtE", 64'(RtE), 64'(m_rte));
        check("RdE", 64'(RdE), 64'(m_rde));
        check("ValidE", 64'(ValidE), 64'(m_valide));
        check("StallCnt", 64'(StallCnt), 64'(m_stall));
        check("FlushCnt", 64'(FlushCnt), 64'(m_flush));
    endtask

    task automatic rand_decode();
        CtrlD    = 8'($urandom);
        RD1D     = $urandom;
        RD2D     = $urandom;
        SignImmD = $urandom;
        RsD      = 5'($urandom);
        RtD      = 5'($urandom);
        RdD      = 5'($urandom);
    endtask

    // Advance one clock: the model applies the stage rules to the inputs present
    // at the edge, then every DUT output is compared just after the edge.
    task automatic tick();
        logic old_validd;
        old_validd = m_validd;
        if (reset) begin
            m_pcf = 32'h0; m_instrd = 32'h0; m_pcp4d = 32'h0; m_validd = 1'b0;
            m_ctrle = 8'h0; m_rd1e = 32'h0; m_rd2e = 32'h0; m_imme = 32'h0;
            m_rse = 5'h0; m_rte = 5'h0; m_rde = 5'h0; m_valide = 1'b0;
            m_stall = 0; m_flush = 0;
        end else begin
            if (!StallF) m_pcf = PCNextF;
            if (!StallD) begin
                if (FlushD) begin
                    m_instrd = 32'h0; m_pcp4d = 32'h0; m_validd = 1'b0;
                end else begin
                    m_instrd = InstrF; m_pcp4d = PCPlus4F; m_validd = 1'b1;
                end
            end
            if (FlushE) begin
                m_ctrle = 8'h0; m_rd1e = 32'h0; m_rd2e = 32'h0; m_imme = 32'h0;
                m_rse = 5'h0; m_rte = 5'h0; m_rde = 5'h0; m_valide = 1'b0;
            end else begin
                m_ctrle = CtrlD; m_rd1e = RD1D; m_rd2e = RD2D; m_imme = SignImmD;
                m_rse = RsD; m_rte = RtD; m_rde = RdD; m_valide = old_validd;
            end
            if (StallD && m_stall < CntMax) m_stall++;
            if ((FlushE || (FlushD && !StallD)) && m_flush < CntMax) m_flush++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ctl(input logic sf, input logic sd, input logic fd, input logic fe);
        StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
    endtask

    initial begin
        reset = 1'b1;
        PCNextF = 32'h40; InstrF = 32'h0; PCPlus4F = 32'h0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        rand_decode();
        m_validd = 1'b0;

        // Reset held two cycles, then release.
        tick();
        tick();
        check("reset_PCF", 64'(PCF), 64'h0);
        check("reset_StallCnt", 64'(StallCnt), 64'h0);
        reset = 1'b0;
        tick();
        check("first_PCF", 64'(PCF), 64'h40);

        // Straight-line flow.
        for (int i = 0; i < 3; i++) begin
            PCNextF = 32'(4 * (i + 1));
            InstrF = 32'hA000_0000 + 32'(i);
            PCPlus4F = 32'(4 * (i + 1));
            rand_decode();
            tick();
        end
        check("flow_ValidE", 64'(ValidE), 64'h1);

        // Load-use: hold PC and IF/ID, bubble ID/EX.
        set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
        rand_decode();
        tick();
        check("loaduse_CtrlE", 64'(CtrlE), 64'h0);
        check("loaduse_ValidE", 64'(ValidE), 64'h0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Taken branch flushes IF/ID.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("branch_InstrD", 64'(InstrD), 64'h0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        InstrF = 32'hB0B0_0001;
        tick();

        // Stall dominates flush in decode; ID/EX still bubbled.
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("stallflush_ValidD", 64'(ValidD), 64'h1);
        check("stallflush_InstrD", 64'(InstrD), 64'hB0B0_0001);

        // Counter saturation at 4 bits.
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_StallCnt", 64'(StallCnt), 64'd15);
        reset = 1'b1;
        tick();
        check("sat_reset", 64'(StallCnt), 64'h0);
        reset = 1'b0;

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            PCNextF = $urandom;
            InstrF = $urandom;
            PCPlus4F = $urandom;
            rand_decode();
            set_ctl(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
